alarm_keypad_ctrl: RTL and testbench

Parametrised home-alarm controller: keypad digit entry, programmable passcode, arm/disarm with exit delay, multi-zone intrusion detection with entry delay, bounded failed attempts, and a flashing alarm output. Sits between the keyboard digit decoder (one-cycle digit/enter strobes) and the sensor/indicator I/O (laser zones, LEDs, buzzer). It replaces the fixed 4-digit, single-sensor, 3-attempt controller.

---
 rtl/alarm_keypad_ctrl_pkg.sv | 26 ++
 rtl/alarm_keypad_ctrl_code_entry_buffer.sv | 64 ++++++
 rtl/alarm_keypad_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_alarm_keypad_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_keypad_ctrl_pkg.sv
// Shared definitions for the alarm keypad controller: state encodings, digit width, helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alarm_keypad_ctrl_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_SETUP    = 3'd0,
    ST_DISARMED = 3'd1,
    ST_ARMING   = 3'd2,
    ST_ARMED    = 3'd3,
    ST_ENTRY    = 3'd4,
    ST_ALARM    = 3'd5
  } state_t;

  // Keypad codes 10..15 are not digits and must never reach the buffer.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_keypad_ctrl_code_entry_buffer.sv
// Keypad entry buffer: shifts in BCD digits, tracks count/overflow, compares with stored code.
// Latency: digit visible in buffer 1 cycle after strobe; match/len_ok combinational from buffer regs.
// Backpressure: none; strobes are always accepted, digits past CODE_DIGITS only raise overflow.
//
// Ports:
//   clock, resetn        clock and synchronous active-low reset
//   digit_valid, digit   one-cycle digit strobe and BCD value (10..15 ignored)
//   enter, clear         either one empties the buffer (enter/clear win over a digit)
//   stored_code          current passcode to compare against
//   entry                buffer contents (used to program the code in SETUP)
//   entry_count          digits held, saturating at CODE_DIGITS
//   len_ok               exactly CODE_DIGITS digits and no overflow
//   match                len_ok and buffer equals stored_code
module alarm_keypad_ctrl_code_entry_buffer
  import alarm_keypad_ctrl_pkg::*;
#(
  parameter int CODE_DIGITS = 4
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             digit_valid,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             enter,
  input  logic                             clear,
  input  logic [CODE_DIGITS*DIGIT_W-1:0]   stored_code,
  output logic [CODE_DIGITS*DIGIT_W-1:0]   entry,
  output logic [3:0]                       entry_count,
  output logic                             len_ok,
  output logic                             match
);

  localparam int          CODE_W    = CODE_DIGITS * DIGIT_W;
  localparam logic [3:0]  COUNT_MAX = 4'(CODE_DIGITS);

  logic [CODE_W-1:0] entry_q;
  logic [3:0]        count_q;
  logic              overflow_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      entry_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (enter || clear) begin
      entry_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (digit_valid && is_bcd(digit)) begin
      if (count_q == COUNT_MAX) begin
        // Too many digits: the entry can no longer match, remember that.
        overflow_q <= 1'b1;
      end else begin
        entry_q <= CODE_W'({entry_q, digit});
        count_q <= count_q + 4'd1;
      end
    end
  end

  assign entry       = entry_q;
  assign entry_count = count_q;
  assign len_ok      = (count_q == COUNT_MAX) && !overflow_q;
  assign match       = len_ok && (entry_q == stored_code);

endmodule

// File: rtl/alarm_keypad_ctrl.sv
// Home-alarm controller: passcode programming, arm/disarm with exit delay, zoned entry delay, alarm flash.
// Latency: all outputs registered; enter/timer/zone decisions take effect at the next clock edge.
// Backpressure: none; keypad strobes are single-cycle and always consumed.
//
// Ports:
//   clock, resetn                 clock and synchronous active-low reset (erases stored code)
//   digit_valid, digit            keypad digit strobe and BCD value
//   enter, clear                  submit / discard current entry
//   zone_trip, zone_mask          per-zone breach level and bypass
//   state                         current FSM state (SETUP..ALARM)
//   armed, alarm, flash           indicator outputs
//   attempts_left                 remaining failed entries before alarm
//   zone_latched                  zones that caused the current ENTRY/ALARM
//   code_ok, code_bad             one-cycle result pulses for an enter
//   entry_count                   digits currently held
module alarm_keypad_ctrl
  import alarm_keypad_ctrl_pkg::*;
#(
  parameter int CODE_DIGITS  = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int ARM_DELAY    = 250000000,
  parameter int ENTRY_DELAY  = 250000000,
  parameter int FLASH_HALF   = 6250000,
  parameter int ZONES        = 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               digit_valid,
  input  logic [3:0]         digit,
  input  logic               enter,
  input  logic               clear,
  input  logic [ZONES-1:0]   zone_trip,
  input  logic [ZONES-1:0]   zone_mask,
  output logic [2:0]         state,
  output logic               armed,
  output logic               alarm,
  output logic               flash,
  output logic [3:0]         attempts_left,
  output logic [ZONES-1:0]   zone_latched,
  output logic               code_ok,
  output logic               code_bad,
  output logic [3:0]         entry_count
);

  localparam int CODE_W = CODE_DIGITS * DIGIT_W;
  localparam int TW     = $clog2(max2(ARM_DELAY, ENTRY_DELAY) + 1);
  localparam int FW     = $clog2(FLASH_HALF + 1);

  localparam logic [TW-1:0] ARM_LOAD   = TW'(ARM_DELAY - 1);
  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_DELAY - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_HALF - 1);
  localparam logic [3:0]    ATT_LOAD   = 4'(MAX_ATTEMPTS);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [3:0]        attempts_q, attempts_d;
  logic [ZONES-1:0]  latched_q, latched_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [FW-1:0]     flash_cnt_q, flash_cnt_d;
  logic              flash_q, flash_d;
  logic              armed_q, alarm_q;
  logic              code_ok_q, code_ok_d;
  logic              code_bad_q, code_bad_d;

  logic [CODE_W-1:0] entry;
  logic              len_ok;
  logic              match;
  logic [ZONES-1:0]  trips;
  logic              timer_done;

  alarm_keypad_ctrl_code_entry_buffer #(
    .CODE_DIGITS (CODE_DIGITS)
  ) u_entry (
    .clock       (clock),
    .resetn      (resetn),
    .digit_valid (digit_valid),
    .digit       (digit),
    .enter       (enter),
    .clear       (clear),
    .stored_code (code_q),
    .entry       (entry),
    .entry_count (entry_count),
    .len_ok      (len_ok),
    .match       (match)
  );

  assign trips      = zone_trip & ~zone_mask;
  assign timer_done = (timer_q == '0);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_SETUP;
      code_q      <= '0;
      attempts_q  <= ATT_LOAD;
      latched_q   <= '0;
      timer_q     <= '0;
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
      armed_q     <= 1'b0;
      alarm_q     <= 1'b0;
      code_ok_q   <= 1'b0;
      code_bad_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      attempts_q  <= attempts_d;
      latched_q   <= latched_d;
      timer_q     <= timer_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      armed_q     <= (state_d == ST_ARMED) || (state_d == ST_ENTRY);
      alarm_q     <= (state_d == ST_ALARM);
      code_ok_q   <= code_ok_d;
      code_bad_q  <= code_bad_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    attempts_d  = attempts_q;
    latched_d   = latched_q;
    // The delay counter free-runs down and parks at zero.
    timer_d     = timer_done ? timer_q : timer_q - TW'(1);
    code_ok_d   = 1'b0;
    code_bad_d  = 1'b0;
    flash_d     = 1'b0;
    flash_cnt_d = '0;

    case (state_q)
      ST_SETUP: begin
        // A malformed entry in SETUP is silently discarded.
        if (enter && len_ok) begin
          code_d  = entry;
          state_d = ST_DISARMED;
        end
      end

      ST_ALARM: begin
        if (enter) begin
          if (match) begin
            code_ok_d  = 1'b1;
            attempts_d = ATT_LOAD;
            state_d    = ST_DISARMED;
          end else begin
            code_bad_d = 1'b1;
          end
        end
      end

      ST_DISARMED, ST_ARMING, ST_ARMED, ST_ENTRY: begin
        // Enter outranks timer expiry, which outranks a zone trip.
        if (enter) begin
          if (match) begin
            code_ok_d  = 1'b1;
            attempts_d = ATT_LOAD;
            if (state_q == ST_DISARMED) begin
              state_d = ST_ARMING;
              timer_d = ARM_LOAD;
            end else begin
              state_d = ST_DISARMED;
            end
          end else begin
            code_bad_d = 1'b1;
            if (attempts_q <= 4'd1) begin
              attempts_d = '0;
              state_d    = ST_ALARM;
            end else begin
              attempts_d = attempts_q - 4'd1;
            end
          end
        end else if (state_q == ST_ARMING && timer_done) begin
          state_d = ST_ARMED;
        end else if (state_q == ST_ENTRY && timer_done) begin
          state_d = ST_ALARM;
        end else if (state_q == ST_ARMED && (|trips)) begin
          state_d   = ST_ENTRY;
          latched_d = latched_q | trips;
          timer_d   = ENTRY_LOAD;
        end else if (state_q == ST_ENTRY) begin
          latched_d = latched_q | trips;
        end
      end

      default: begin
        state_d = ST_SETUP;
      end
    endcase

    if (state_d == ST_DISARMED) begin
      latched_d = '0;
    end

    // Flash starts lit on entry to ALARM, then toggles every FLASH_HALF cycles.
    if (state_d == ST_ALARM) begin
      if (state_q != ST_ALARM) begin
        flash_d     = 1'b1;
        flash_cnt_d = FLASH_LOAD;
      end else if (flash_cnt_q == '0) begin
        flash_d     = ~flash_q;
        flash_cnt_d = FLASH_LOAD;
      end else begin
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q - FW'(1);
      end
    end
  end

  assign state         = state_q;
  assign armed         = armed_q;
  assign alarm         = alarm_q;
  assign flash         = flash_q;
  assign attempts_left = attempts_q;
  assign zone_latched  = latched_q;
  assign code_ok       = code_ok_q;
  assign code_bad      = code_bad_q;

endmodule

// File: tb/tb_alarm_keypad_ctrl.sv
// Directed bench for alarm_keypad_ctrl with short delays and four zones.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next edge.
// Backpressure: n/a.
module tb_alarm_keypad_ctrl;

  logic       clock;
  logic       resetn;
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter;
  logic       clear;
  logic [3:0] zone_trip;
  logic [3:0] zone_mask;
  logic [2:0] state;
  logic       armed;
  logic       alarm;
  logic       flash;
  logic [3:0] attempts_left;
  logic [3:0] zone_latched;
  logic       code_ok;
  logic       code_bad;
  logic [3:0] entry_count;

  int n_total = 0;
  int n_bad   = 0;

  alarm_keypad_ctrl #(
    .CODE_DIGITS  (4),
    .MAX_ATTEMPTS (3),
    .ARM_DELAY    (8),
    .ENTRY_DELAY  (16),
    .FLASH_HALF   (4),
    .ZONES        (4)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .digit_valid   (digit_valid),
    .digit         (digit),
    .enter         (enter),
    .clear         (clear),
    .zone_trip     (zone_trip),
    .zone_mask     (zone_mask),
    .state         (state),
    .armed         (armed),
    .alarm         (alarm),
    .flash         (flash),
    .attempts_left (attempts_left),
    .zone_latched  (zone_latched),
    .code_ok       (code_ok),
    .code_bad      (code_bad),
    .entry_count   (entry_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    step(1);
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    enter = 1'b1;
    step(1);
    enter = 1'b0;
  endtask

  initial begin
    resetn      = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
    enter       = 1'b0;
    clear       = 1'b0;
    zone_trip   = 4'd0;
    zone_mask   = 4'd0;
    step(2);

    // Reset state
    chk("rst_state", state, 0);
    chk("rst_attempts", attempts_left, 3);
    chk("rst_armed", armed, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_flash", flash, 0);
    chk("rst_latched", zone_latched, 0);
    chk("rst_count", entry_count, 0);
    resetn = 1'b1;
    step(1);

    // SETUP: short entry is discarded without penalty
    press(4'd7);
    enter = 1'b1; step(1); enter = 1'b0;
    chk("setup_short_state", state, 0);
    chk("setup_short_bad", code_bad, 0);
    chk("setup_short_att", attempts_left, 3);
    chk("setup_short_cnt", entry_count, 0);

    // SETUP: program 1234
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("setup_cnt4", entry_count, 4);
    enter = 1'b1; step(1); enter = 1'b0;
    chk("setup_done_state", state, 1);
    chk("setup_no_ok", code_ok, 0);
    chk("setup_cnt0", entry_count, 0);

    // Arm: exit delay of exactly 8 cycles
    enter_code(16'h1234);
    chk("arm_ok", code_ok, 1);
    chk("arm_state", state, 2);
    chk("arm_armed0", armed, 0);
    step(1);
    chk("arm_ok_pulse", code_ok, 0);
    step(6);
    chk("arming_at7", state, 2);
    step(1);
    chk("armed_at8", state, 3);
    chk("armed_flag", armed, 1);

    // Masked zone does not trigger
    zone_mask = 4'b0001;
    zone_trip = 4'b0001;
    step(3);
    chk("masked_state", state, 3);
    chk("masked_latched", zone_latched, 0);
    zone_trip = 4'b0000;
    zone_mask = 4'b0000;

    // Zone 2 trip -> ENTRY next cycle, then ALARM after 16 cycles
    zone_trip = 4'b0100;
    step(1);
    zone_trip = 4'b0000;
    chk("entry_state", state, 4);
    chk("entry_latched", zone_latched, 4'b0100);
    chk("entry_armed", armed, 1);
    step(15);
    chk("entry_at15", state, 4);
    step(1);
    chk("alarm_at16", state, 5);
    chk("alarm_flag", alarm, 1);
    chk("alarm_armed0", armed, 0);
    for (int i = 0; i < 8; i++) begin
      chk("flash_seq", flash, ((i / 4) % 2 == 0) ? 1 : 0);
      step(1);
    end

    // Correct code clears ALARM
    enter_code(16'h1234);
    chk("dis_ok", code_ok, 1);
    chk("dis_state", state, 1);
    chk("dis_latched", zone_latched, 0);
    chk("dis_alarm", alarm, 0);
    chk("dis_flash", flash, 0);

    // Re-arm, then three wrong codes
    enter_code(16'h1234);
    step(8);
    chk("rearm_state", state, 3);
    enter_code(16'h9999);
    chk("bad1_pulse", code_bad, 1);
    chk("bad1_att", attempts_left, 2);
    chk("bad1_state", state, 3);
    enter_code(16'h9999);
    chk("bad2_att", attempts_left, 1);
    enter_code(16'h9999);
    chk("bad3_att", attempts_left, 0);
    chk("bad3_state", state, 5);
    chk("bad3_alarm", alarm, 1);
    enter_code(16'h9999);
    chk("alarm_bad_pulse", code_bad, 1);
    chk("alarm_bad_att", attempts_left, 0);
    enter_code(16'h1234);
    chk("recover_state", state, 1);
    chk("recover_att", attempts_left, 3);
    chk("recover_latched", zone_latched, 0);

    // Non-BCD digit ignored, clear empties buffer
    press(4'd12);
    chk("digit12_cnt", entry_count, 0);
    press(4'd5);
    chk("one_digit_cnt", entry_count, 1);
    clear = 1'b1; step(1); clear = 1'b0;
    chk("clear_cnt", entry_count, 0);

    // Five digits -> overflow rejected
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    chk("ovf_cnt", entry_count, 4);
    enter = 1'b1; step(1); enter = 1'b0;
    chk("ovf_bad", code_bad, 1);
    chk("ovf_state", state, 1);
    chk("ovf_att", attempts_left, 2);

    // Correct enter on the exact cycle the entry delay expires
    enter_code(16'h1234);
    chk("arm2_att", attempts_left, 3);
    step(8);
    chk("arm2_state", state, 3);
    zone_trip = 4'b0001;
    step(1);
    zone_trip = 4'b0000;
    chk("entry2_state", state, 4);
    chk("entry2_latched", zone_latched, 4'b0001);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    step(11);
    chk("entry2_at15", state, 4);
    enter = 1'b1; step(1); enter = 1'b0;
    chk("race_state", state, 1);
    chk("race_alarm", alarm, 0);
    chk("race_ok", code_ok, 1);

    // Reach ALARM from DISARMED, then reset mid-alarm
    enter_code(16'h9999);
    enter_code(16'h9999);
    enter_code(16'h9999);
    chk("pre_rst_alarm", alarm, 1);
    resetn = 1'b0;
    step(1);
    chk("rst2_state", state, 0);
    chk("rst2_alarm", alarm, 0);
    chk("rst2_flash", flash, 0);
    chk("rst2_armed", armed, 0);
    chk("rst2_att", attempts_left, 3);
    chk("rst2_bad", code_bad, 0);
    resetn = 1'b1;
    step(1);

    // Stored code was erased: new code programs, old one rejected
    enter_code(16'h5678);
    chk("reprog_state", state, 1);
    enter_code(16'h1234);
    chk("old_code_bad", code_bad, 1);
    chk("old_code_state", state, 1);
    enter_code(16'h5678);
    chk("new_code_ok", code_ok, 1);
    chk("new_code_state", state, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
